// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matrix_pkg
// Description : Shared types, sizes and element packing for matrix_loader.
// Revision    : 1.0
// ============================================================================
package matrix_pkg;

   localparam int ELEM_W_DEF = 8;
   localparam int DIM        = 3;
   localparam int NUM_ELEMS  = DIM * DIM;
   localparam int FRAME_LEN  = 2 * NUM_ELEMS;
   localparam int IDX_W      = 5;

   typedef enum logic [1:0] {
      FILL      = 2'd0,
      ARM       = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_e;

   // Row-major linear position of element (r,c).
   function automatic int elem_pos(input int r, input int c);
      return DIM * r + c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_loader.sv
`default_nettype none
// ============================================================================
// Module      : matrix_loader
// Description : Byte-serial frame assembler and Load/Done sequencer for the
//               3x3 matrix multiplier.
// Revision    : 1.0
// ============================================================================
module matrix_loader
   import matrix_pkg::*;
#(
   parameter int ELEM_W = ELEM_W_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [ELEM_W-1:0]           in_data,
   input  logic                        in_valid,
   input  logic                        in_last,
   output logic                        in_ready,
   output logic [NUM_ELEMS*ELEM_W-1:0] a_flat,
   output logic [NUM_ELEMS*ELEM_W-1:0] b_flat,
   output logic                        mm_load,
   input  logic                        mm_done,
   output logic                        busy,
   output logic                        result_valid,
   output logic                        frame_err
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [ELEM_W-1:0] bank_q [FRAME_LEN];
   logic [ELEM_W-1:0] bank_d [FRAME_LEN];
   logic              load_q, load_d;
   logic              busy_q, busy_d;
   logic              rv_q, rv_d;
   logic              ferr_q, ferr_d;
   logic              xfer;
   logic              at_last;

   assign in_ready = (state_q == FILL);
   assign xfer     = in_valid & in_ready;
   assign at_last  = (idx_q == LAST_IDX);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      bank_d  = bank_q;
      load_d  = 1'b0;
      busy_d  = busy_q;
      rv_d    = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         FILL: begin
            if (xfer) begin
               bank_d[idx_q] = in_data;
               if (in_last && at_last) begin
                  idx_d   = '0;
                  state_d = ARM;
               end else if (in_last || at_last) begin
                  // Short or overlong frame: restart the fill, keep bank contents.
                  idx_d  = '0;
                  ferr_d = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         ARM: begin
            if (mm_done) begin
               load_d  = 1'b1;
               busy_d  = 1'b1;
               state_d = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (!mm_done) begin
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (mm_done) begin
               rv_d    = 1'b1;
               busy_d  = 1'b0;
               state_d = FILL;
            end
         end
         default: begin
            state_d = FILL;
            idx_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FILL;
         idx_q   <= '0;
         for (int i = 0; i < FRAME_LEN; i++) begin
            bank_q[i] <= '0;
         end
         load_q  <= 1'b0;
         busy_q  <= 1'b0;
         rv_q    <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         bank_q  <= bank_d;
         load_q  <= load_d;
         busy_q  <= busy_d;
         rv_q    <= rv_d;
         ferr_q  <= ferr_d;
      end
   end

   for (genvar r = 0; r < DIM; r++) begin : g_row
      for (genvar c = 0; c < DIM; c++) begin : g_col
         localparam int POS = elem_pos(r, c);
         assign a_flat[ELEM_W*POS +: ELEM_W] = bank_q[POS];
         assign b_flat[ELEM_W*POS +: ELEM_W] = bank_q[NUM_ELEMS+POS];
      end
   end

   assign mm_load      = load_q;
   assign busy         = busy_q;
   assign result_valid = rv_q;
   assign frame_err    = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_loader
// Description : Self-checking bench for matrix_loader with a behavioural
//               multiplier and a reference matrix product.
// Revision    : 1.0
// ============================================================================
module tb_matrix_loader;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_last = 1'b0;
   logic         in_ready;
   logic [9*W-1:0] a_flat;
   logic [9*W-1:0] b_flat;
   logic         mm_load;
   logic         mm_done;
   logic         busy;
   logic         result_valid;
   logic         frame_err;

   int checks = 0;
   int errors = 0;
   int loads  = 0;

   logic [W-1:0] mA [9];
   logic [W-1:0] mB [9];

   matrix_loader #(.ELEM_W(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_last      (in_last),
      .in_ready     (in_ready),
      .a_flat       (a_flat),
      .b_flat       (b_flat),
      .mm_load      (mm_load),
      .mm_done      (mm_done),
      .busy         (busy),
      .result_valid (result_valid),
      .frame_err    (frame_err)
   );

   always #5 clk = ~clk;

   // Behavioural multiplier: Done drops the cycle after Load, returns later.
   logic mul_done;
   int   mul_cnt;
   int   mul_c [9];
   int   mul_s;
   logic hold_low = 1'b0;
   assign mm_done = mul_done & ~hold_low;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mul_done <= 1'b1;
         mul_cnt  <= 0;
      end else if (mm_load && mul_done) begin
         for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
               mul_s = 0;
               for (int k = 0; k < 3; k++) begin
                  mul_s = mul_s + int'(a_flat[W*(3*i+k) +: W]) * int'(b_flat[W*(3*k+j) +: W]);
               end
               mul_c[3*i+j] <= mul_s;
            end
         end
         mul_done <= 1'b0;
         mul_cnt  <= 5;
      end else if (!mul_done) begin
         if (mul_cnt <= 1) mul_done <= 1'b1;
         mul_cnt <= mul_cnt - 1;
      end
   end

   always @(negedge clk) begin
      if (mm_load) loads++;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h required=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9*W-1:0] pack_ref(input bit sel_b);
      logic [9*W-1:0] v;
      v = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            v[W*(3*r+c) +: W] = sel_b ? mB[3*r+c] : mA[3*r+c];
      return v;
   endfunction

   function automatic int ref_c(input int i, input int j);
      int s;
      s = 0;
      for (int k = 0; k < 3; k++) s = s + int'(mA[3*i+k]) * int'(mB[3*k+j]);
      return s;
   endfunction

   task automatic rand_mats();
      for (int i = 0; i < 9; i++) begin
         mA[i] = W'($urandom);
         mB[i] = W'($urandom);
      end
   endtask

   task automatic push(input logic [W-1:0] d, input logic last, input bit bubbles);
      int n;
      @(negedge clk);
      if (bubbles) begin
         n = $urandom_range(0, 2);
         repeat (n) @(negedge clk);
      end
      in_data  = d;
      in_valid = 1'b1;
      in_last  = last;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("push_timeout", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_frame(input bit bubbles);
      for (int i = 0; i < 18; i++) push(i < 9 ? mA[i] : mB[i-9], i == 17, bubbles);
   endtask

   task automatic post_last(input string tag);
      chk({tag, ":ready_low"}, in_ready, 0);
      chk({tag, ":a_flat"}, a_flat, pack_ref(1'b0));
      chk({tag, ":b_flat"}, b_flat, pack_ref(1'b1));
      chk({tag, ":no_load_yet"}, mm_load, 0);
   endtask

   task automatic run_mult(input string tag, input bit inject);
      int base;
      int n;
      logic [9*W-1:0] sa, sb;
      base = loads;
      @(posedge clk); #1;
      chk({tag, ":load"}, mm_load, 1);
      chk({tag, ":busy"}, busy, 1);
      @(posedge clk); #1;
      chk({tag, ":load_off"}, mm_load, 0);
      if (inject) begin
         @(posedge clk); #1;
         sa = a_flat;
         sb = b_flat;
         for (int i = 0; i < 2; i++) begin
            in_data  = W'($urandom);
            in_valid = 1'b1;
            in_last  = 1'($urandom);
            @(posedge clk); #1;
            chk({tag, ":inj_ready"}, in_ready, 0);
            chk({tag, ":inj_a"}, a_flat, pack_ref(1'b0));
            chk({tag, ":inj_b"}, b_flat, sb);
         end
         in_valid = 1'b0;
         in_last  = 1'b0;
         chk({tag, ":inj_a_hold"}, a_flat, sa);
      end
      n = 0;
      while (!result_valid && n < 100) begin
         chk({tag, ":busy_hold"}, busy, 1);
         @(posedge clk); #1;
         n++;
      end
      chk({tag, ":rv"}, result_valid, 1);
      chk({tag, ":busy_clr"}, busy, 0);
      chk({tag, ":ready_back"}, in_ready, 1);
      chk({tag, ":one_load"}, loads - base, 1);
      for (int i = 0; i < 9; i++) chk({tag, ":prod"}, mul_c[i], ref_c(i / 3, i % 3));
      @(posedge clk); #1;
      chk({tag, ":rv_pulse"}, result_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;

      // Reset values
      #12;
      chk("rst:ready", in_ready, 1);
      chk("rst:a", a_flat, 0);
      chk("rst:b", b_flat, 0);
      chk("rst:load", mm_load, 0);
      chk("rst:busy", busy, 0);
      chk("rst:rv", result_valid, 0);
      chk("rst:ferr", frame_err, 0);
      @(negedge clk);
      rst = 1'b0;

      // Directed frame A=1..9, B=9..1
      for (int i = 0; i < 9; i++) begin
         mA[i] = W'(i + 1);
         mB[i] = W'(9 - i);
      end
      send_frame(1'b0);
      post_last("dir");
      chk("dir:a00", a_flat[7:0], 1);
      chk("dir:a22", a_flat[71:64], 9);
      chk("dir:b00", b_flat[7:0], 9);
      run_mult("dir", 1'b0);
      chk("dir:c00", mul_c[0], 30);

      // in_last on the 5th element
      rand_mats();
      base = loads;
      for (int i = 0; i < 4; i++) push(W'($urandom), 1'b0, 1'b0);
      push(W'($urandom), 1'b1, 1'b0);
      chk("short:ferr", frame_err, 1);
      chk("short:ready", in_ready, 1);
      @(posedge clk); #1;
      chk("short:ferr_pulse", frame_err, 0);
      repeat (4) @(posedge clk);
      #1;
      chk("short:no_load", loads - base, 0);
      send_frame(1'b1);
      post_last("after_short");
      run_mult("after_short", 1'b0);

      // 18th element without in_last
      for (int i = 0; i < 18; i++) push(W'($urandom), 1'b0, 1'b0);
      chk("long:ferr", frame_err, 1);
      chk("long:ready", in_ready, 1);
      rand_mats();
      send_frame(1'b0);
      post_last("after_long");
      run_mult("after_long", 1'b0);

      // mm_done held low when the frame completes
      rand_mats();
      @(negedge clk);
      hold_low = 1'b1;
      send_frame(1'b1);
      post_last("hold");
      base = loads;
      repeat (5) @(posedge clk);
      #1;
      chk("hold:no_load", loads - base, 0);
      chk("hold:load_low", mm_load, 0);
      chk("hold:ready_low", in_ready, 0);
      chk("hold:busy_low", busy, 0);
      hold_low = 1'b0;
      run_mult("hold", 1'b0);

      // in_valid during the multiply is ignored
      rand_mats();
      send_frame(1'b0);
      post_last("inj");
      run_mult("inj", 1'b1);

      // Reset during WAIT_DONE
      rand_mats();
      send_frame(1'b0);
      post_last("mrst");
      @(posedge clk); #1;
      repeat (3) @(posedge clk);
      #1;
      chk("mrst:busy", busy, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("mrst:ready", in_ready, 1);
      chk("mrst:a", a_flat, 0);
      chk("mrst:b", b_flat, 0);
      chk("mrst:load", mm_load, 0);
      chk("mrst:busy_clr", busy, 0);
      chk("mrst:rv", result_valid, 0);
      chk("mrst:ferr", frame_err, 0);
      @(negedge clk);
      rst = 1'b0;
      rand_mats();
      send_frame(1'b1);
      post_last("post_rst");
      run_mult("post_rst", 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/matrix_loader.md
# matrix_loader

Upstream feeder for the 3x3 matrix multiplier. Accepts a byte-serial stream of 18 elements (A row-major, then B row-major) over a valid/ready handshake and assembles them into a register bank. It drives the multiplier's eighteen element inputs and pulses its Load, then tracks its Done to report completion. Operand registers are held stable for the whole multiply.

## Interface
- ELEM_W, 8, element width in bits; must match the multiplier.
- clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- in_data  input  ELEM_W  stream element.
- in_valid  input  1  in_data valid.
- in_last  input  1  marks the final (18th) element of a frame.
- in_ready  output  1  loader accepts an element this cycle.
- a_flat  output  9*ELEM_W  A operands; element (r,c) at bits [ELEM_W*(3r+c) +: ELEM_W].
- b_flat  output  9*ELEM_W  B operands, same packing.
- mm_load  output  1  Load strobe to the multiplier.
- mm_done  input  1  Done from the multiplier (high = idle).
- busy  output  1  high from mm_load until the multiply completes.
- result_valid  output  1  one-cycle pulse: multiplier outputs are final.
- frame_err  output  1  one-cycle pulse: framing error, frame discarded.

## Operation
- States: FILL, ARM, WAIT_BUSY, WAIT_DONE.
- FILL:
  - in_ready=1.
  - An element transfers on a rising edge with in_valid&in_ready.
  - A 5-bit index (0..17) steers it: 0-8 into A[idx], 9-17 into B[idx-9].
  - Index increments per transfer.
- Framing:
  - Transfer at idx=17 with in_last=1: frame complete. Idx->0, go to ARM.
  - Transfer with in_last=1 at idx<17, or at idx=17 with in_last=0: frame_err pulse, idx->0, stay in FILL.
  - Already-written registers keep their values; they are overwritten by the next frame.
- ARM:
  - in_ready=0.
  - If mm_done=1: mm_load=1 for exactly one cycle, busy=1, go to WAIT_BUSY.
  - Else hold in ARM.
- WAIT_BUSY: wait for mm_done=0 (multiplier started), then go to WAIT_DONE.
- WAIT_DONE:
  - On mm_done=1: result_valid=1 for one cycle, busy->0, go to FILL.
  - in_ready rises in the same cycle as result_valid.
- a_flat/b_flat change only on FILL transfers; they are constant from ARM through WAIT_DONE.
- No arithmetic beyond the index counter; the index never exceeds 17.

## Timing
- Reset values:
  - state=FILL, idx=0, in_ready=1.
  - a_flat=0, b_flat=0.
  - mm_load=0, busy=0, result_valid=0, frame_err=0.
- All outputs are registered except in_ready, which is decoded from state.
- Fill takes 18 transfers minimum (18 cycles back-to-back). Bubbles on in_valid are allowed.
- Last transfer at edge N:
  - State is ARM in cycle N+1.
  - mm_load is high in cycle N+2 if mm_done=1.
- mm_load is never high two consecutive cycles.
- WAIT_BUSY→WAIT_DONE occurs the cycle after mm_done is sampled low. The multiplier drops Done one cycle after Load.
- result_valid is asserted the cycle after mm_done is sampled high in WAIT_DONE.
- in_valid while in_ready=0 is ignored; the upstream must hold its data.
- Reset mid-operation (any state) clears everything immediately and asynchronously. The multiplier shares Reset and also returns to idle.
- frame_err and a successful completion never coincide.

## Structure
- Shared package matrix_pkg holds:
  - ELEM_W default and DIM=3.
  - NUM_ELEMS=9 and FRAME_LEN=18.
  - State encodings FILL/ARM/WAIT_BUSY/WAIT_DONE.
  - Packing helper for the (r,c) offset.
- Single module; no sub-module.
- The register bank is one 18-entry array written by idx.

## Test plan
- Reset, then stream A=1..9 and B=9..1 back-to-back with in_last on element 18, mm_done tied to a model multiplier. Required:
  - a_flat[7:0]=1 and a_flat[71:64]=9; b_flat[7:0]=9.
  - One mm_load pulse two cycles after the last transfer.
  - busy high until result_valid.
  - Model outputs match A×B (element 00 = 1·9+2·6+3·3=30).
- in_last on the 5th element → frame_err pulse, no mm_load. Then a full valid frame loads and runs normally.
- 18th element without in_last → frame_err, idx=0, state FILL.
- Hold mm_done=0 when the frame completes → stays in ARM with no mm_load. Raise mm_done → exactly one mm_load.
- Drive in_valid with new data during WAIT_DONE → in_ready=0 and a_flat/b_flat unchanged.
- Assert Reset during WAIT_DONE → all outputs at reset values immediately. A fresh frame afterward completes with result_valid.
